uart_baud_ctrl: RTL and testbench
=================================

# uart_baud_ctrl

Programmable baud-tick controller for the on-chip 8250-style UART in the FPGA 8088 system. A 32-bit DDS phase accumulator derives a 1.8432 MHz reference enable from the 50 MHz system clock. A CPU-programmed 16-bit divisor latch divides that reference into single-cycle `tick16` (16× oversample) and `bit_tick` enables. The block owns divisor staging and glitch-free reload, so UART TX/RX logic runs entirely on `clk_50m` with clock enables instead of a derived clock.

## Interface
- `PHASE_STEP`, default 32'd158_329_674: accumulator increment; ref rate = 50 MHz × `PHASE_STEP` / 2^32.
- `DIV_RESET`, default 16'd12: divisor loaded at reset (9600 baud).
- `clk_50m`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `addr`  in  2  register select: 0 DLL, 1 DLM, 2 CTRL, 3 STATUS.
- `wr_en`  in  1  single-cycle write strobe.
- `rd_en`  in  1  single-cycle read strobe.
- `wr_data`  in  8  write data.
- `rd_data`  out  8  read data; registered.
- `rd_valid`  out  1  one-cycle pulse, asserted the cycle after `rd_en`.
- `ref_tick`  out  1  1.8432 MHz-rate enable pulse.
- `tick16`  out  1  16× baud enable pulse.
- `bit_tick`  out  1  1× baud enable pulse; coincides with every 16th `tick16`.
- `running`  out  1  state is RUN or PEND.

## Operation
- Accumulator: `acc <= acc + PHASE_STEP` every cycle, mod 2^32. `ref_tick` is a registered pulse of the carry out, so it is high the cycle after a wrap. The accumulator always runs, whether stopped or enabled.
- Registers:
  - DLL/DLM writes update `div_stage[7:0]` / `div_stage[15:8]` only.
  - CTRL bit0 `en`: enables tick generation.
  - CTRL bit1 `load`: self-clearing; requests a commit of `div_stage`.
  - CTRL bit2 `clr`: self-clearing; zeroes the divide and oversample counters.
- Reads:
  - DLL/DLM return `div_stage` bytes.
  - CTRL returns {5'b0, 2'b0, en}.
  - STATUS returns {5'b0, div_act==0, pend, running}.
- `div_act` is the active divisor. The divide counter `dcnt` counts `ref_tick` pulses 0..div_act−1. `tick16` fires on the `ref_tick` where `dcnt == div_act−1`; `dcnt` then returns to 0. The oversample counter `ocnt` counts `tick16` pulses 0..15; `bit_tick` fires with the `tick16` where `ocnt == 15`.
- FSM states:
  - STOP: no ticks; counters held at 0. Go to RUN when `en`=1 and `div_act`≠0.
  - RUN: ticks active. A `load` write goes to PEND. `en`=0 goes to STOP.
  - PEND: ticks continue with the old divisor. On the next `tick16`, copy `div_stage` to `div_act`, clear `dcnt`, and go to RUN. If the new `div_act`==0, go to STOP instead. `en`=0 goes to STOP and commits immediately.
- A `load` write in STOP commits `div_stage` to `div_act` in the same cycle.
- Divisor 0 means stopped. It is never committed into RUN; in STOP it is committed and the block stays in STOP.
- Divisor 1 produces `tick16` on every `ref_tick`.

## Timing
- Reset values:
  - `acc`=0, `dcnt`=0, `ocnt`=0.
  - `div_stage`=`div_act`=`DIV_RESET`.
  - `en`=0, state STOP.
  - `rd_data`=0, `rd_valid`=0.
  - `ref_tick`=`tick16`=`bit_tick`=0, `running`=0.
- Reset asserted mid-operation forces these values on the next edge; ticks drop immediately.
- `tick16` and `bit_tick` are registered pulses, one cycle after the qualifying `ref_tick`. None of the three ticks is ever high for two consecutive cycles unless `PHASE_STEP` ≥ 2^31.
- `en` write to RUN: the first `tick16` fires after `div_act` `ref_tick` pulses. `running` rises the cycle after the write.
- `wr_en` and `rd_en` in the same cycle: both are serviced. Read data reflects the pre-write value.
- `load` and `clr` in the same write: `clr` applies immediately. The commit follows PEND or STOP rules.
- A second `load` while in PEND keeps the state in PEND; the latest `div_stage` is the one committed.
- `clr` in PEND clears the counters but does not commit the staged divisor.

## Structure
- Shared package `uart_pkg`:
  - Register address constants (`UART_DLL`, `UART_DLM`, `UART_CTRL`, `UART_STATUS`).
  - CTRL/STATUS bit indices.
  - FSM state encoding.
  - Default `PHASE_STEP`.
- One sub-module: `uart_dds_ref`, the phase accumulator plus registered carry pulse. It is reused wherever a rate enable is needed. The FSM, registers and divide counters stay in `uart_baud_ctrl`.

## Test plan
- Set `PHASE_STEP`=2^30, release reset, write CTRL=0x01 → `ref_tick` every 4 cycles; `tick16` every 48 cycles; `bit_tick` every 768 cycles; `running`=1 one cycle after the write.
- In RUN, divisor 12, write DLL=0x03 then CTRL=0x03 → STATUS reads 0x03 (pend, running). The 48-cycle spacing holds until the next `tick16`; thereafter spacing is 12 cycles and STATUS reads 0x01.
- In STOP, write DLL=0x00, DLM=0x00, CTRL=0x02, then CTRL=0x01 → no ticks, `running`=0, STATUS=0x04.
- Divisor 1, `PHASE_STEP`=2^31 → `tick16` every 2 cycles, `bit_tick` every 32 cycles; pulses are exactly one cycle wide.
- Assert `rst_n`=0 for one cycle mid-PEND → next cycle: all outputs 0, `div_act`=12, STATUS read gives 0x00.
- Read DLM with `rd_en` and a write to DLM of 0x5A in the same cycle → `rd_data`=0x00 with `rd_valid` one cycle later; a following read returns 0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART baud-tick controller: register map,
// CTRL/STATUS bit positions, FSM encoding and the default DDS step.
package uart_pkg;

   // Register select values on addr
   localparam logic [1:0] UART_DLL    = 2'd0;
   localparam logic [1:0] UART_DLM    = 2'd1;
   localparam logic [1:0] UART_CTRL   = 2'd2;
   localparam logic [1:0] UART_STATUS = 2'd3;

   // CTRL bit positions
   localparam int CTRL_EN   = 0;
   localparam int CTRL_LOAD = 1;
   localparam int CTRL_CLR  = 2;

   // STATUS bit positions
   localparam int STAT_RUN  = 0;
   localparam int STAT_PEND = 1;
   localparam int STAT_DIV0 = 2;

   // Tick generator state
   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   // 50 MHz * step / 2^32 ~= 1.8432 MHz
   localparam logic [31:0] PHASE_STEP_DFLT = 32'd158_329_674;

endpackage

// File: rtl/uart_dds_ref.sv
// DDS rate-enable generator: a free-running 32-bit phase accumulator whose
// carry out is registered into a single-cycle enable pulse.
module uart_dds_ref
   import uart_pkg::*;
#(
   parameter logic [31:0] STEP = PHASE_STEP_DFLT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   logic [31:0] r_acc;
   logic        r_tick;
   logic [32:0] w_sum;

   assign w_sum  = {1'b0, r_acc} + {1'b0, STEP};
   assign o_tick = r_tick;

   // Advance the phase every cycle; the pulse is high the cycle after a wrap
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_acc  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_acc  <= w_sum[31:0];
         r_tick <= w_sum[32];
      end
   end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Programmable baud-tick controller: divisor latch staging, glitch-free
// divisor reload and tick16 / bit_tick enable generation on clk_50m.
module uart_baud_ctrl
   import uart_pkg::*;
#(
   parameter logic [31:0] PHASE_STEP = PHASE_STEP_DFLT,
   parameter logic [15:0] DIV_RESET  = 16'd12
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic [1:0] addr,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       ref_tick,
   output logic       tick16,
   output logic       bit_tick,
   output logic       running
);

   state_t      r_state;
   logic [15:0] r_div_stage;
   logic [15:0] r_div_act;
   logic [15:0] r_dcnt;
   logic [3:0]  r_ocnt;
   logic        r_en;
   logic        r_tick16;
   logic        r_bit_tick;
   logic        r_running;
   logic [7:0]  r_rd_data;
   logic        r_rd_valid;

   logic        w_ref;
   logic        w_wr_ctrl;
   logic        w_en_eff;
   logic        w_load;
   logic        w_clr;
   logic        w_active;
   logic        w_last;
   logic        w_evt;
   logic [15:0] w_div_new;
   logic [7:0]  w_status;
   logic        w_unused;

   uart_dds_ref #(.STEP(PHASE_STEP)) u_ref (
      .i_clk   (clk_50m),
      .i_rst_n (rst_n),
      .o_tick  (w_ref)
   );

   // A CTRL write takes effect in its own cycle so running rises on the next
   assign w_wr_ctrl = wr_en && (addr == UART_CTRL);
   assign w_en_eff  = w_wr_ctrl ? wr_data[CTRL_EN] : r_en;
   assign w_load    = w_wr_ctrl && wr_data[CTRL_LOAD];
   assign w_clr     = w_wr_ctrl && wr_data[CTRL_CLR];
   assign w_active  = (r_state != ST_STOP);
   assign w_last    = (r_dcnt == r_div_act - 16'd1);
   // Qualifying ref_tick: the registered tick16 follows one cycle later
   assign w_evt     = w_active && w_en_eff && w_ref && w_last && !w_clr;
   assign w_div_new = w_load ? r_div_stage : r_div_act;
   assign w_status  = {5'b0, (r_div_act == 16'd0), (r_state == ST_PEND), r_running};
   assign w_unused  = &{1'b0, wr_data[7:3]};

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign ref_tick = w_ref;
   assign tick16   = r_tick16;
   assign bit_tick = r_bit_tick;
   assign running  = r_running;

   // CPU-visible divisor staging and enable bit
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         r_div_stage <= DIV_RESET;
         r_en        <= 1'b0;
      end else begin
         if (wr_en && (addr == UART_DLL)) r_div_stage[7:0]  <= wr_data;
         if (wr_en && (addr == UART_DLM)) r_div_stage[15:8] <= wr_data;
         if (w_wr_ctrl)                   r_en              <= wr_data[CTRL_EN];
      end
   end

   // Tick FSM with divide/oversample counters and divisor commit
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         r_state    <= ST_STOP;
         r_div_act  <= DIV_RESET;
         r_dcnt     <= '0;
         r_ocnt     <= '0;
         r_tick16   <= 1'b0;
         r_bit_tick <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_tick16   <= w_evt;
         r_bit_tick <= w_evt && (r_ocnt == 4'd15);

         if (w_clr) begin
            r_dcnt <= '0;
            r_ocnt <= '0;
         end else if (w_evt) begin
            r_dcnt <= '0;
            r_ocnt <= r_ocnt + 4'd1;
         end else if (w_active && w_ref) begin
            r_dcnt <= r_dcnt + 16'd1;
         end

         // Transitions below override the counter updates when stopping
         case (r_state)
            ST_STOP: begin
               if (w_load) r_div_act <= r_div_stage;
               if (w_en_eff && (w_div_new != 16'd0)) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!w_en_eff) begin
                  if (w_load) r_div_act <= r_div_stage;
                  r_state   <= ST_STOP;
                  r_running <= 1'b0;
                  r_dcnt    <= '0;
                  r_ocnt    <= '0;
               end else if (w_load) begin
                  r_state <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (!w_en_eff) begin
                  r_div_act <= r_div_stage;
                  r_state   <= ST_STOP;
                  r_running <= 1'b0;
                  r_dcnt    <= '0;
                  r_ocnt    <= '0;
               end else if (w_evt) begin
                  // Swap divisors on a tick16 boundary so no short period escapes
                  r_div_act <= r_div_stage;
                  if (r_div_stage == 16'd0) begin
                     r_state   <= ST_STOP;
                     r_running <= 1'b0;
                     r_dcnt    <= '0;
                     r_ocnt    <= '0;
                  end else if (!w_load) begin
                     r_state <= ST_RUN;
                  end
               end
            end
            default: begin
               r_state   <= ST_STOP;
               r_running <= 1'b0;
               r_dcnt    <= '0;
               r_ocnt    <= '0;
            end
         endcase
      end
   end

   // Registered read port; sees state from before any same-cycle write
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) begin
            case (addr)
               UART_DLL:  r_rd_data <= r_div_stage[7:0];
               UART_DLM:  r_rd_data <= r_div_stage[15:8];
               UART_CTRL: r_rd_data <= {7'b0, r_en};
               default:   r_rd_data <= w_status;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Bench for uart_baud_ctrl: register vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_uart_baud_ctrl;
   import uart_pkg::*;

   localparam logic [31:0] STEP_A = 32'h4000_0000;
   localparam logic [31:0] STEP_B = 32'h8000_0000;
   localparam longint      STEP_L = 64'h4000_0000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] addr = '0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] wr_data = '0;

   logic [7:0] a_rd, b_rd;
   logic       a_rdv, a_ref, a_t16, a_bit, a_run;
   logic       b_rdv, b_ref, b_t16, b_bit, b_run;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_baud_ctrl #(.PHASE_STEP(STEP_A), .DIV_RESET(16'd12)) dut_a (
      .clk_50m(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
      .wr_data(wr_data), .rd_data(a_rd), .rd_valid(a_rdv), .ref_tick(a_ref),
      .tick16(a_t16), .bit_tick(a_bit), .running(a_run)
   );

   uart_baud_ctrl #(.PHASE_STEP(STEP_B), .DIV_RESET(16'd12)) dut_b (
      .clk_50m(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
      .wr_data(wr_data), .rd_data(b_rd), .rd_valid(b_rdv), .ref_tick(b_ref),
      .tick16(b_t16), .bit_tick(b_bit), .running(b_run)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model of dut_a ----------------
   // Ticks are derived from the number of ref pulses elapsed: ref pulse k
   // occurs after edge c when floor(c*step/2^32) steps up.
   longint     cyc;
   int         m_mode;      // 0 stopped, 1 running, 2 reload pending
   bit [15:0]  m_stage, m_act;
   bit         m_en;
   int         m_refs, m_os;
   bit         m_ctrl, m_enn, m_ld, m_cl, m_fire;
   bit         e_ref, e_t16, e_bit, e_run, e_rdv;
   bit [7:0]   e_rd;
   bit         chk_on = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode = 0; m_stage = 16'd12; m_act = 16'd12; m_en = 0;
         m_refs = 0; m_os = 0; cyc = 0;
         e_ref = 0; e_t16 = 0; e_bit = 0; e_run = 0; e_rdv = 0; e_rd = 0;
         chk_on = 1'b1;
      end else begin
         e_rdv = rd_en;
         if (rd_en) begin
            case (addr)
               2'd0:    e_rd = m_stage[7:0];
               2'd1:    e_rd = m_stage[15:8];
               2'd2:    e_rd = {7'b0, m_en};
               default: e_rd = {5'b0, m_act == 0, m_mode == 2, m_mode != 0};
            endcase
         end
         m_ctrl = wr_en && (addr == 2'd2);
         m_enn  = m_ctrl ? wr_data[0] : m_en;
         m_ld   = m_ctrl && wr_data[1];
         m_cl   = m_ctrl && wr_data[2];
         m_fire = 0;
         if (m_mode != 0 && m_enn && !m_cl && e_ref) begin
            m_refs++;
            if (m_refs == int'(m_act)) m_fire = 1;
         end
         e_t16 = m_fire;
         e_bit = m_fire && (m_os == 15);
         if (m_fire) begin m_refs = 0; m_os = (m_os + 1) % 16; end
         if (m_cl) begin m_refs = 0; m_os = 0; end
         case (m_mode)
            0: begin
               if (m_ld) m_act = m_stage;
               if (m_enn && m_act != 0) m_mode = 1;
            end
            1: begin
               if (!m_enn) begin if (m_ld) m_act = m_stage; m_mode = 0; end
               else if (m_ld) m_mode = 2;
            end
            default: begin
               if (!m_enn) begin m_act = m_stage; m_mode = 0; end
               else if (m_fire) begin
                  m_act  = m_stage;
                  m_mode = (m_act == 0) ? 0 : (m_ld ? 2 : 1);
               end
            end
         endcase
         if (m_mode == 0) begin m_refs = 0; m_os = 0; end
         e_run = (m_mode != 0);
         if (wr_en && addr == 2'd0) m_stage[7:0]  = wr_data;
         if (wr_en && addr == 2'd1) m_stage[15:8] = wr_data;
         if (m_ctrl) m_en = wr_data[0];
         e_ref = (((cyc + 1) * STEP_L) >> 32) != ((cyc * STEP_L) >> 32);
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("mdl_ref",    a_ref, e_ref);
         chk("mdl_tick16", a_t16, e_t16);
         chk("mdl_bit",    a_bit, e_bit);
         chk("mdl_run",    a_run, e_run);
         chk("mdl_rdv",    a_rdv, e_rdv);
         chk("mdl_rdata",  a_rd,  e_rd);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic bus(input bit w, input bit r, input logic [1:0] a, input logic [7:0] d);
      wr_en = w; rd_en = r; addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 0; rd_en = 0;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: return a_t16;
         1: return a_bit;
         2: return b_t16;
         3: return b_bit;
         default: return a_ref;
      endcase
   endfunction

   // Cycles until the selected pulse is next seen high; -1 on timeout
   task automatic wait_hi(input int sel, input int bound, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!sig(sel) && n < bound);
      if (!sig(sel)) begin
         n_chk++; n_err++;
         $display("FAIL wait sel=%0d timed out after %0d cycles", sel, n);
         n = -1;
      end
   endtask

   typedef struct {
      bit         wr;
      bit         rd;
      logic [1:0] a;
      logic [7:0] d;
      logic [7:0] exp_rd;
      bit         exp_run;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int n;
      int r;
      tbl.push_back('{0, 1, UART_DLL,    8'h00, 8'h0C, 0});
      tbl.push_back('{0, 1, UART_DLM,    8'h00, 8'h00, 0});
      tbl.push_back('{0, 1, UART_CTRL,   8'h00, 8'h00, 0});
      tbl.push_back('{0, 1, UART_STATUS, 8'h00, 8'h00, 0});
      tbl.push_back('{1, 1, UART_DLM,    8'h5A, 8'h00, 0});
      tbl.push_back('{0, 1, UART_DLM,    8'h00, 8'h5A, 0});
      tbl.push_back('{1, 1, UART_DLM,    8'h00, 8'h5A, 0});
      tbl.push_back('{1, 0, UART_DLL,    8'h00, 8'h00, 0});
      tbl.push_back('{1, 0, UART_CTRL,   8'h02, 8'h00, 0});
      tbl.push_back('{0, 1, UART_STATUS, 8'h00, 8'h04, 0});
      tbl.push_back('{1, 0, UART_CTRL,   8'h01, 8'h00, 0});
      tbl.push_back('{0, 1, UART_STATUS, 8'h00, 8'h04, 0});
      tbl.push_back('{0, 1, UART_CTRL,   8'h00, 8'h01, 0});
      tbl.push_back('{1, 0, UART_DLL,    8'h0C, 8'h00, 0});
      tbl.push_back('{1, 0, UART_CTRL,   8'h02, 8'h00, 0});
      tbl.push_back('{0, 1, UART_STATUS, 8'h00, 8'h00, 0});
      tbl.push_back('{1, 0, UART_CTRL,   8'h01, 8'h00, 1});
      tbl.push_back('{0, 1, UART_STATUS, 8'h00, 8'h01, 1});
      tbl.push_back('{0, 1, UART_DLL,    8'h00, 8'h0C, 1});

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ref", a_ref, 0); chk("rst_t16", a_t16, 0); chk("rst_bit", a_bit, 0);
      chk("rst_run", a_run, 0); chk("rst_rdv", a_rdv, 0); chk("rst_rd", a_rd, 0);
      rst_n = 1'b1;

      // Register vectors
      foreach (tbl[i]) begin
         bus(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
         chk($sformatf("vec%0d_rdv", i), a_rdv, tbl[i].rd);
         if (tbl[i].rd) chk($sformatf("vec%0d_rd", i), a_rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_run", i), a_run, tbl[i].exp_run);
      end

      // Divisor 12 rates
      wait_hi(4, 20, n); wait_hi(4, 20, n);     chk("ref_gap", n, 4);
      wait_hi(0, 200, n); wait_hi(0, 200, n);   chk("t16_gap12", n, 48);
      wait_hi(1, 2000, n); wait_hi(1, 2000, n); chk("bit_gap12", n, 768);

      // Reload in RUN: old spacing until the next tick16, then divisor 3
      wait_hi(0, 200, n);
      bus(1, 0, UART_DLL, 8'h03);
      bus(1, 0, UART_CTRL, 8'h03);
      bus(0, 1, UART_STATUS, 8'h00);
      chk("pend_status", a_rd, 8'h03);
      wait_hi(0, 200, n); chk("pend_old_gap", n + 3, 48);
      wait_hi(0, 200, n); chk("t16_gap3", n, 12);
      bus(0, 1, UART_STATUS, 8'h00);
      chk("run_status", a_rd, 8'h01);

      // One-cycle reset in the middle of a pending reload
      bus(1, 0, UART_DLL, 8'h0C);
      bus(1, 0, UART_CTRL, 8'h03);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_ref", a_ref, 0); chk("mid_rst_t16", a_t16, 0);
      chk("mid_rst_bit", a_bit, 0); chk("mid_rst_run", a_run, 0);
      chk("mid_rst_rdv", a_rdv, 0); chk("mid_rst_rd", a_rd, 0);
      chk("mid_rst_b_t16", b_t16, 0); chk("mid_rst_b_run", b_run, 0);
      bus(0, 1, UART_STATUS, 8'h00); chk("mid_rst_status", a_rd, 8'h00);
      bus(0, 1, UART_CTRL, 8'h00);   chk("mid_rst_ctrl", a_rd, 8'h00);
      bus(1, 0, UART_CTRL, 8'h01);
      wait_hi(0, 200, n); wait_hi(0, 200, n); chk("post_rst_gap", n, 48);

      // Divisor 1: tick16 on every ref pulse
      bus(1, 0, UART_DLL, 8'h01);
      bus(1, 0, UART_CTRL, 8'h03);
      wait_hi(3, 200, n);
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         chk("div1_b_t16", b_t16, (i % 2) == 0);
         chk("div1_b_bit", b_bit, (i % 32) == 0);
      end
      wait_hi(0, 50, n); wait_hi(0, 50, n); chk("div1_a_gap", n, 4);

      // Randomized traffic checked by the model
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 60) @(negedge clk);
         else if (r < 75) bus(0, 1, 2'($urandom_range(0, 3)), 8'h00);
         else if (r < 85) bus(1, 0, UART_DLL, 8'($urandom_range(0, 5)));
         else if (r < 88) bus(1, 0, UART_DLM, ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00);
         else if (r < 98) bus(1, 0, UART_CTRL,
                              {5'b0, ($urandom_range(0, 4) == 0),
                               1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)});
         else if (r < 99) bus(1, 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)));
         else begin rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; end
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
